iobus_intr_ctrl: RTL and testbench



---
 rtl/iobus_intr_ctrl_if.sv | 38 +++
 rtl/iobus_intr_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_iobus_intr_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iobus_intr_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : iobus_intr_ctrl_if                                      |
// | Brief    : IOBUS register port plus event lines and interrupt out  |
// |            for the interrupt controller.                           |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface iobus_intr_ctrl_if #(
  parameter int N_SRC = 4
);
  logic [31:0]      i_iobus_addr;
  logic [31:0]      i_iobus_out;
  logic             i_iobus_wr;
  logic [31:0]      o_rd_data;
  logic [N_SRC-1:0] i_src_in;
  logic             o_cpu_intr;

  // MCU / wrapper side
  modport master (
    output i_iobus_addr,
    output i_iobus_out,
    output i_iobus_wr,
    output i_src_in,
    input  o_rd_data,
    input  o_cpu_intr
  );

  // Controller side
  modport slave (
    input  i_iobus_addr,
    input  i_iobus_out,
    input  i_iobus_wr,
    input  i_src_in,
    output o_rd_data,
    output o_cpu_intr
  );
endinterface
`default_nettype wire

// File: rtl/iobus_intr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : iobus_intr_ctrl                                         |
// | Brief    : Edge-latching, masked, lowest-index-first interrupt     |
// |            controller with fixed-width CPU_INTR pulse and          |
// |            software acknowledge on the OTTER IOBUS.                |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module iobus_intr_ctrl #(
  parameter logic [31:0] BASE_AD   = 32'h11000060,
  parameter int          N_SRC     = 4,
  parameter int          INTR_HOLD = 2
) (
  input  logic               clk,
  input  logic               rst,
  iobus_intr_ctrl_if.slave   bus
);

  localparam logic [31:0] c_ADDR_ENABLE  = BASE_AD;
  localparam logic [31:0] c_ADDR_PENDING = BASE_AD + 32'd4;
  localparam logic [31:0] c_ADDR_ID      = BASE_AD + 32'd8;
  localparam logic [31:0] c_ADDR_ACK     = BASE_AD + 32'd12;
  localparam int          c_CNT_W        = (INTR_HOLD > 1) ? $clog2(INTR_HOLD) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(INTR_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [N_SRC-1:0]   r_sync1;
  logic [N_SRC-1:0]   r_sync2;
  logic [N_SRC-1:0]   r_dly;
  logic [N_SRC-1:0]   r_enable;
  logic [N_SRC-1:0]   r_pending;
  logic               r_id_valid;
  logic [3:0]         r_id_idx;
  logic [c_CNT_W-1:0] r_cnt;

  logic [N_SRC-1:0]   w_rise;
  logic [N_SRC-1:0]   w_cand;
  logic [3:0]         w_cand_idx;
  logic [N_SRC-1:0]   w_w1c;
  logic [N_SRC-1:0]   w_ack_clr;
  logic               w_wr_enable;
  logic               w_wr_pending;
  logic               w_wr_ack;
  logic               w_dispatch;
  logic               w_ack_take;
  logic               w_cpu_intr;
  logic [31:0]        w_rd_data;
  logic               w_unused;

  // Upper write-data bits carry nothing for this block
  assign w_unused = &{1'b0, bus.i_iobus_out};

  assign w_wr_enable  = bus.i_iobus_wr && (bus.i_iobus_addr == c_ADDR_ENABLE);
  assign w_wr_pending = bus.i_iobus_wr && (bus.i_iobus_addr == c_ADDR_PENDING);
  assign w_wr_ack     = bus.i_iobus_wr && (bus.i_iobus_addr == c_ADDR_ACK);

  // Rising edge of the synchronized line, independent of the mask
  assign w_rise = r_sync2 & ~r_dly;
  assign w_w1c  = w_wr_pending ? bus.i_iobus_out[N_SRC-1:0] : '0;

  // Candidate vector and lowest-index priority encoder
  always_comb begin
    w_cand     = r_pending & r_enable;
    w_cand_idx = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_cand_idx = 4'(i);
    end
  end

  // One-hot clear of the dispatched source on an accepted acknowledge
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_ack_clr[i] = w_ack_take && (r_id_idx == 4'(i));
    end
  end

  // Dispatch FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Dispatch FSM next-state and outputs
  always_comb begin
    w_state_next = r_state;
    w_dispatch   = 1'b0;
    w_ack_take   = 1'b0;
    w_cpu_intr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_cand) begin
          w_dispatch   = 1'b1;
          w_state_next = S_ASSERT;
        end
      end
      S_ASSERT: begin
        w_cpu_intr = 1'b1;
        if (r_cnt == '0) w_state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (w_wr_ack) begin
          w_ack_take   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Two-flop synchronizer plus edge-detect delay flop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dly   <= '0;
    end else begin
      r_sync1 <= bus.i_src_in;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  // Enable mask and pending bits; a same-cycle edge beats any clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable  <= '0;
      r_pending <= '0;
    end else begin
      if (w_wr_enable) r_enable <= bus.i_iobus_out[N_SRC-1:0];
      r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_rise;
    end
  end

  // Latched source ID and pulse-width counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_idx   <= 4'd0;
      r_cnt      <= '0;
    end else begin
      if (w_dispatch) begin
        r_id_valid <= 1'b1;
        r_id_idx   <= w_cand_idx;
        r_cnt      <= c_HOLD_LOAD;
      end else begin
        if (w_ack_take) begin
          r_id_valid <= 1'b0;
          r_id_idx   <= 4'd0;
        end
        if (r_state == S_ASSERT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Zero-latency register read mux
  always_comb begin
    w_rd_data = 32'd0;
    if (bus.i_iobus_addr == c_ADDR_ENABLE) begin
      w_rd_data[N_SRC-1:0] = r_enable;
    end else if (bus.i_iobus_addr == c_ADDR_PENDING) begin
      w_rd_data[N_SRC-1:0] = r_pending;
    end else if (bus.i_iobus_addr == c_ADDR_ID) begin
      w_rd_data[31]  = r_id_valid;
      w_rd_data[3:0] = r_id_idx;
    end
  end

  assign bus.o_rd_data  = w_rd_data;
  assign bus.o_cpu_intr = w_cpu_intr;

endmodule
`default_nettype wire

// File: tb/tb_iobus_intr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_iobus_intr_ctrl                                      |
// | Brief    : Directed bench with a cycle-level behavioural model     |
// |            of the interrupt controller.                            |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_iobus_intr_ctrl;

  localparam logic [31:0] c_BASE = 32'h11000060;
  localparam int          c_HOLD = 2;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic started  = 1'b0;

  iobus_intr_ctrl_if #(.N_SRC(4)) bus ();

  iobus_intr_ctrl #(
    .BASE_AD   (c_BASE),
    .N_SRC     (4),
    .INTR_HOLD (c_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: sample history, pending mask, dispatched ID and
  // remaining pulse cycles.
  logic [3:0] m_h0, m_h1, m_h2;
  logic [3:0] m_pend, m_en;
  logic       m_valid;
  int         m_idx;
  int         m_left;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == c_BASE)        return {28'd0, m_en};
    if (a == c_BASE + 4)    return {28'd0, m_pend};
    if (a == c_BASE + 8)    return m_valid ? (32'h80000000 | 32'(m_idx)) : 32'd0;
    return 32'd0;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] clr;
    logic [3:0] rise;
    logic [3:0] cand;
    started <= 1'b1;
    if (rst) begin
      m_h0 <= 0; m_h1 <= 0; m_h2 <= 0;
      m_pend <= 0; m_en <= 0; m_valid <= 0; m_idx <= 0; m_left <= 0;
    end else begin
      rise = m_h1 & ~m_h2;
      clr  = 4'd0;
      if (bus.i_iobus_wr && bus.i_iobus_addr == c_BASE + 4) clr = bus.i_iobus_out[3:0];
      if (bus.i_iobus_wr && bus.i_iobus_addr == c_BASE + 12 && m_valid && m_left == 0) begin
        clr[m_idx] = 1'b1;
        m_valid    <= 1'b0;
        m_idx      <= 0;
      end
      m_pend <= (m_pend & ~clr) | rise;
      m_h0 <= bus.i_src_in; m_h1 <= m_h0; m_h2 <= m_h1;
      if (bus.i_iobus_wr && bus.i_iobus_addr == c_BASE) m_en <= bus.i_iobus_out[3:0];
      cand = m_pend & m_en;
      if (!m_valid && cand != 0) begin
        m_valid <= 1'b1;
        m_idx   <= lowest(cand);
        m_left  <= c_HOLD;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model_cpu_intr", {31'd0, bus.o_cpu_intr}, {31'd0, (m_left > 0)});
      chk("model_rd_data", bus.o_rd_data, exp_rd(bus.i_iobus_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.i_iobus_addr = a;
    bus.i_iobus_out  = d;
    bus.i_iobus_wr   = 1'b1;
    tick();
    bus.i_iobus_wr   = 1'b0;
    bus.i_iobus_out  = 32'd0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.i_iobus_addr = a;
    #1;
    chk(nm, bus.o_rd_data, exp);
  endtask

  task automatic cpu_chk(input string nm, input logic exp);
    chk(nm, {31'd0, bus.o_cpu_intr}, {31'd0, exp});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_iobus_addr = 32'd0;
    bus.i_iobus_out  = 32'd0;
    bus.i_iobus_wr   = 1'b0;
    bus.i_src_in     = 4'hF;

    // Reset with all sources high
    tick();
    cpu_chk("rst_cpu_intr", 1'b0);
    rd_chk("rst_enable",  c_BASE,     32'd0);
    rd_chk("rst_pending", c_BASE + 4, 32'd0);
    rd_chk("rst_id",      c_BASE + 8, 32'd0);
    tick();
    rst = 1'b0;
    ticks(3);
    rd_chk("post_rst_pending", c_BASE + 4, 32'h0000000F);
    cpu_chk("post_rst_no_intr", 1'b0);
    bus.i_src_in = 4'h0;
    wr(c_BASE + 4, 32'hF);
    rd_chk("w1c_all", c_BASE + 4, 32'd0);
    ticks(3);

    // Single source
    wr(c_BASE, 32'h4);
    bus.i_src_in = 4'b0100;
    ticks(3);
    rd_chk("single_pending", c_BASE + 4, 32'h4);
    cpu_chk("single_before", 1'b0);
    tick();
    cpu_chk("single_hi0", 1'b1);
    tick();
    cpu_chk("single_hi1", 1'b1);
    tick();
    cpu_chk("single_lo", 1'b0);
    rd_chk("single_id", c_BASE + 8, 32'h80000002);
    wr(c_BASE + 12, 32'hDEAD);
    rd_chk("single_ack_pend", c_BASE + 4, 32'd0);
    rd_chk("single_ack_id",   c_BASE + 8, 32'd0);
    ticks(3);
    cpu_chk("single_no_repend", 1'b0);
    rd_chk("level_no_repend", c_BASE + 4, 32'd0);
    bus.i_src_in = 4'h0;
    ticks(3);

    // Priority
    wr(c_BASE, 32'hF);
    bus.i_src_in = 4'b1010;
    ticks(4);
    rd_chk("prio_first_id", c_BASE + 8, 32'h80000001);
    ticks(2);
    wr(c_BASE + 12, 32'd0);
    cpu_chk("prio_gap", 1'b0);
    tick();
    cpu_chk("prio_second_hi", 1'b1);
    rd_chk("prio_second_id", c_BASE + 8, 32'h80000003);
    ticks(2);
    wr(c_BASE + 12, 32'd0);
    bus.i_src_in = 4'h0;
    ticks(3);

    // Mask
    wr(c_BASE, 32'h0);
    bus.i_src_in = 4'b0001;
    ticks(4);
    rd_chk("mask_pending", c_BASE + 4, 32'h1);
    cpu_chk("mask_no_intr", 1'b0);
    wr(c_BASE, 32'h1);
    cpu_chk("mask_enable_edge", 1'b0);
    tick();
    cpu_chk("mask_intr", 1'b1);
    ticks(2);
    wr(c_BASE + 12, 32'd0);
    wr(c_BASE, 32'h0);
    bus.i_src_in = 4'h0;
    ticks(3);
    bus.i_src_in = 4'b0001;
    ticks(3);
    rd_chk("mask_repend", c_BASE + 4, 32'h1);
    wr(c_BASE + 4, 32'h1);
    rd_chk("mask_w1c", c_BASE + 4, 32'd0);
    bus.i_src_in = 4'h0;
    ticks(3);

    // Collision: W1C on the same edge that sets the bit
    bus.i_src_in = 4'b0100;
    ticks(2);
    wr(c_BASE + 4, 32'h4);
    rd_chk("collide_set_wins", c_BASE + 4, 32'h4);
    wr(c_BASE, 32'h4);
    tick();
    cpu_chk("collide_assert", 1'b1);
    wr(c_BASE + 12, 32'd0);
    cpu_chk("ack_in_assert_hi", 1'b1);
    tick();
    cpu_chk("ack_in_assert_wait", 1'b0);
    rd_chk("ack_in_assert_id", c_BASE + 8, 32'h80000002);
    rd_chk("ack_in_assert_pend", c_BASE + 4, 32'h4);
    wr(c_BASE + 8, 32'd0);
    rd_chk("id_ro", c_BASE + 8, 32'h80000002);
    wr(c_BASE + 12, 32'd0);
    rd_chk("collide_ack_pend", c_BASE + 4, 32'd0);

    // Mid-operation reset
    bus.i_src_in = 4'h0;
    ticks(3);
    bus.i_src_in = 4'b0100;
    ticks(4);
    cpu_chk("midrst_hi", 1'b1);
    rst = 1'b1;
    tick();
    cpu_chk("midrst_cpu", 1'b0);
    rd_chk("midrst_id", c_BASE + 8, 32'd0);
    rd_chk("midrst_en", c_BASE, 32'd0);
    rd_chk("unmapped", 32'h11000070, 32'd0);
    rst = 1'b0;
    bus.i_src_in = 4'h0;
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
